// File: rtl/adc_responder_pkg.sv
// ---------------------------------------------------------------------------
// adc_responder_pkg
// Shared definitions for the ADC responder: FSM state encoding, channel and
// data widths, default temperature-sensor channel, the invalid-data code and
// small helpers for result selection and packet-framing bookkeeping.
// No ports (package).
// ---------------------------------------------------------------------------
package adc_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CH_W           = 5;
  localparam int DATA_W         = 12;
  localparam int CNT_W          = 8;
  localparam int TS_CHANNEL_DEF = 17;

  localparam logic [DATA_W-1:0] INVALID_DATA = 12'hFFF;

  // Result word: out-of-range channels always report the invalid code,
  // otherwise either the external sample or {channel, conversion count}.
  function automatic logic [DATA_W-1:0] conv_result(
    input logic              ch_invalid,
    input logic              ext_en,
    input logic [DATA_W-1:0] ext_data,
    input logic [CH_W-1:0]   ch,
    input logic [CNT_W-1:0]  cnt
  );
    logic [DATA_W-1:0] res;
    if (ch_invalid) begin
      res = INVALID_DATA;
    end else if (ext_en) begin
      res = ext_data;
    end else begin
      res = {ch[3:0], cnt};
    end
    return res;
  endfunction

  // Packet flag after an accepted command. EOP wins so that SOP=EOP=1
  // leaves the flag clear (complete single-command packet).
  function automatic logic pkt_next(
    input logic sop,
    input logic eop,
    input logic flag
  );
    logic res;
    if (eop) begin
      res = 1'b0;
    end else if (sop) begin
      res = 1'b1;
    end else begin
      res = flag;
    end
    return res;
  endfunction

  // Framing violation: SOP while a packet is open, or a continuation
  // command (SOP=0) while no packet is open.
  function automatic logic framing_err(
    input logic sop,
    input logic flag
  );
    logic res;
    if (sop) begin
      res = flag;
    end else begin
      res = ~flag;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_responder_timer.sv
// ---------------------------------------------------------------------------
// adc_responder_timer
// Loadable 8-bit down-counter used to time a conversion.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   clr      in   synchronous clear to 0 (highest priority)
//   load     in   load load_val
//   load_val in   8-bit value to load
//   en       in   decrement by one (holds at 0)
//   zero     out  count == 0
// ---------------------------------------------------------------------------
module adc_responder_timer
  import adc_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Down-counter: clear > load > decrement; never underflows past zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 8'd0);

endmodule

// File: rtl/adc_responder.sv
// ---------------------------------------------------------------------------
// adc_responder
// Behavioural ADC command/response responder. Accepts one command at a time
// while the conversion PLL is locked, waits CONV_CYCLES, then emits a single
// response strobe carrying the channel, a result word and the command's
// SOP/EOP. Tracks packet framing and raises a sticky PROTO_ERR.
// Ports:
//   CLK, RESETn          clock (rising edge), async active-low reset
//   ADC_PLL_LOCKED       commands accepted only while high; loss aborts CONV
//   ADC_C_Valid/Ready    command handshake (accept on Valid&Ready)
//   ADC_C_Channel[4:0]   requested channel
//   ADC_C_SOP/EOP        command packet framing
//   ADC_R_Valid          one-cycle response strobe (no backpressure)
//   ADC_R_Channel[4:0]   channel of the response
//   ADC_R_Data[11:0]     conversion result
//   ADC_R_SOP/EOP        copies of the accepted command's SOP/EOP
//   EXT_DATA_EN          select EXT_DATA as the result source
//   EXT_DATA[11:0]       external sample value
//   PROTO_ERR            sticky framing error
// ---------------------------------------------------------------------------
module adc_responder
  import adc_responder_pkg::*;
#(
  parameter int CONV_CYCLES = 20,
  parameter int TS_CHANNEL  = TS_CHANNEL_DEF
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              ADC_PLL_LOCKED,
  input  logic              ADC_C_Valid,
  input  logic [CH_W-1:0]   ADC_C_Channel,
  input  logic              ADC_C_SOP,
  input  logic              ADC_C_EOP,
  output logic              ADC_C_Ready,
  output logic              ADC_R_Valid,
  output logic [CH_W-1:0]   ADC_R_Channel,
  output logic [DATA_W-1:0] ADC_R_Data,
  output logic              ADC_R_SOP,
  output logic              ADC_R_EOP,
  input  logic              EXT_DATA_EN,
  input  logic [DATA_W-1:0] EXT_DATA,
  output logic              PROTO_ERR
);

  // Timer holds CONV_CYCLES-1 at acceptance so that RESP is entered on
  // the CONV_CYCLES-th edge after the accepting edge.
  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CH_W:0]    TS_LIMIT   = (CH_W + 1)'(TS_CHANNEL);

  state_t            state_r;
  state_t            state_next_s;

  logic              ready_s;
  logic              accept_s;
  logic              timer_load_s;
  logic              timer_en_s;
  logic              timer_clr_s;
  logic              timer_zero_s;
  logic              enter_resp_s;
  logic              ch_invalid_s;

  logic [CH_W-1:0]   ch_r;
  logic              sop_r;
  logic              eop_r;
  logic [CNT_W-1:0]  conv_cnt_r;
  logic              pkt_r;
  logic              proto_err_r;

  logic              r_valid_r;
  logic [CH_W-1:0]   r_channel_r;
  logic [DATA_W-1:0] r_data_r;
  logic              r_sop_r;
  logic              r_eop_r;

  adc_responder_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESETn),
    .clr      (timer_clr_s),
    .load     (timer_load_s),
    .load_val (TIMER_LOAD),
    .en       (timer_en_s),
    .zero     (timer_zero_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; lock loss during CONV aborts back to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_CONV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (!ADC_PLL_LOCKED) begin
          state_next_s = ST_IDLE;
        end else if (timer_zero_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_CONV;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshake and timer control.
  // Ready must be combinational on the lock input so that the first edge
  // after reset release can already accept; RESETn is folded in so Ready
  // is forced low while reset is asserted.
  always_comb begin
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    timer_clr_s  = 1'b0;
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s      = ADC_PLL_LOCKED & RESETn;
        accept_s     = ready_s & ADC_C_Valid;
        timer_load_s = accept_s;
      end
      ST_CONV: begin
        if (!ADC_PLL_LOCKED) begin
          timer_clr_s = 1'b1;
        end else if (timer_zero_s) begin
          enter_resp_s = 1'b1;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      ST_RESP: begin
        ready_s = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  assign ch_invalid_s = ({1'b0, ch_r} > TS_LIMIT);

  // Command capture and packet-framing tracking on acceptance.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ch_r        <= 5'd0;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      pkt_r       <= 1'b0;
      proto_err_r <= 1'b0;
    end else if (accept_s) begin
      ch_r        <= ADC_C_Channel;
      sop_r       <= ADC_C_SOP;
      eop_r       <= ADC_C_EOP;
      pkt_r       <= pkt_next(ADC_C_SOP, ADC_C_EOP, pkt_r);
      proto_err_r <= proto_err_r | framing_err(ADC_C_SOP, pkt_r);
    end else begin
      ch_r        <= ch_r;
      sop_r       <= sop_r;
      eop_r       <= eop_r;
      pkt_r       <= pkt_r;
      proto_err_r <= proto_err_r;
    end
  end

  // Conversion counter advances once per delivered response (wraps at 255).
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      conv_cnt_r <= 8'd0;
    end else if (state_r == ST_RESP) begin
      conv_cnt_r <= conv_cnt_r + 8'd1;
    end else begin
      conv_cnt_r <= conv_cnt_r;
    end
  end

  // Response registers: loaded on the CONV->RESP edge, held until the next.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_valid_r   <= 1'b0;
      r_channel_r <= 5'd0;
      r_data_r    <= 12'd0;
      r_sop_r     <= 1'b0;
      r_eop_r     <= 1'b0;
    end else if (enter_resp_s) begin
      r_valid_r   <= 1'b1;
      r_channel_r <= ch_r;
      r_data_r    <= conv_result(ch_invalid_s, EXT_DATA_EN, EXT_DATA, ch_r, conv_cnt_r);
      r_sop_r     <= sop_r;
      r_eop_r     <= eop_r;
    end else begin
      r_valid_r   <= 1'b0;
      r_channel_r <= r_channel_r;
      r_data_r    <= r_data_r;
      r_sop_r     <= r_sop_r;
      r_eop_r     <= r_eop_r;
    end
  end

  assign ADC_C_Ready   = ready_s;
  assign ADC_R_Valid   = r_valid_r;
  assign ADC_R_Channel = r_channel_r;
  assign ADC_R_Data    = r_data_r;
  assign ADC_R_SOP     = r_sop_r;
  assign ADC_R_EOP     = r_eop_r;
  assign PROTO_ERR     = proto_err_r;

endmodule

// File: tb/tb_adc_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_responder
// Directed self-checking bench for adc_responder with default parameters
// (CONV_CYCLES=20, TS_CHANNEL=17). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_adc_responder;

  localparam int CONV = 20;

  logic        clk;
  logic        rst_n;
  logic        locked;
  logic        c_valid;
  logic [4:0]  c_channel;
  logic        c_sop;
  logic        c_eop;
  logic        c_ready;
  logic        r_valid;
  logic [4:0]  r_channel;
  logic [11:0] r_data;
  logic        r_sop;
  logic        r_eop;
  logic        ext_en;
  logic [11:0] ext_data;
  logic        proto_err;

  int n_checks = 0;
  int n_errors = 0;

  adc_responder dut (
    .CLK            (clk),
    .RESETn         (rst_n),
    .ADC_PLL_LOCKED (locked),
    .ADC_C_Valid    (c_valid),
    .ADC_C_Channel  (c_channel),
    .ADC_C_SOP      (c_sop),
    .ADC_C_EOP      (c_eop),
    .ADC_C_Ready    (c_ready),
    .ADC_R_Valid    (r_valid),
    .ADC_R_Channel  (r_channel),
    .ADC_R_Data     (r_data),
    .ADC_R_SOP      (r_sop),
    .ADC_R_EOP      (r_eop),
    .EXT_DATA_EN    (ext_en),
    .EXT_DATA       (ext_data),
    .PROTO_ERR      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Assert reset mid-cycle, check asynchronous output values, release at a
  // falling edge so the next rising edge is the first one after release.
  task automatic do_reset();
    @(negedge clk);
    c_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("rst_ready",   32'(c_ready),   32'd0);
    check_eq("rst_valid",   32'(r_valid),   32'd0);
    check_eq("rst_channel", 32'(r_channel), 32'd0);
    check_eq("rst_data",    32'(r_data),    32'd0);
    check_eq("rst_sop",     32'(r_sop),     32'd0);
    check_eq("rst_eop",     32'(r_eop),     32'd0);
    check_eq("rst_proto",   32'(proto_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present a command mid-cycle and let the next rising edge accept it.
  task automatic send_cmd(input logic [4:0] ch, input logic sop, input logic eop);
    c_valid   = 1'b1;
    c_channel = ch;
    c_sop     = sop;
    c_eop     = eop;
    #1;
    check_eq("cmd_ready", 32'(c_ready), 32'd1);
    @(posedge clk);
    #1;
    c_valid = 1'b0;
  endtask

  // Wait (bounded) for the response strobe and check its contents, then
  // check that it lasted one cycle and Ready came back.
  task automatic wait_resp(input string tag, input int exp_lat, input logic [4:0] ch,
                           input logic [11:0] data, input logic sop, input logic eop);
    int lat;
    int seen;
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= CONV + 10 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (r_valid) begin
        seen = 1;
        lat  = i;
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen == 1) begin
      check_eq({tag, "_lat"},  32'(lat),       32'(exp_lat));
      check_eq({tag, "_ch"},   32'(r_channel), 32'(ch));
      check_eq({tag, "_data"}, 32'(r_data),    32'(data));
      check_eq({tag, "_sop"},  32'(r_sop),     32'(sop));
      check_eq({tag, "_eop"},  32'(r_eop),     32'(eop));
      @(posedge clk);
      #1;
      check_eq({tag, "_strobe1"}, 32'(r_valid), 32'd0);
      check_eq({tag, "_ready"},   32'(c_ready), 32'd1);
      check_eq({tag, "_hold"},    32'(r_data),  32'(data));
    end
  endtask

  // Count response strobes and Ready-high cycles over a window.
  task automatic quiet_window(input string tag, input int cycles, input int exp_ready);
    int nv;
    int nr;
    nv = 0;
    nr = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (r_valid) nv++;
      if (c_ready) nr++;
    end
    check_eq({tag, "_novalid"}, 32'(nv), 32'd0);
    check_eq({tag, "_ready"},   32'(nr), 32'(exp_ready));
  endtask

  task automatic test_basic();
    do_reset();
    send_cmd(5'd3, 1'b1, 1'b1);
    wait_resp("basic", CONV, 5'd3, 12'h300, 1'b1, 1'b1);
    check_eq("basic_proto", 32'(proto_err), 32'd0);
  endtask

  // Valid held high: Ready-gated acceptance, strobes 22 edges apart
  // (20 conversion + RESP + IDLE).
  task automatic test_held_valid();
    int resp_n;
    int stamps[4];
    logic [11:0] datas[4];
    resp_n = 0;
    do_reset();
    c_valid   = 1'b1;
    c_channel = 5'd1;
    c_sop     = 1'b1;
    c_eop     = 1'b1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge clk);
      #1;
      if (r_valid) begin
        if (resp_n < 4) begin
          stamps[resp_n] = cyc;
          datas[resp_n]  = r_data;
        end
        resp_n++;
        if (resp_n == 4) c_valid = 1'b0;
      end
    end
    c_valid = 1'b0;
    check_eq("held_count", 32'(resp_n), 32'd4);
    check_eq("held_first", 32'(stamps[0]), 32'(CONV));
    for (int i = 0; i < 4; i++) begin
      check_eq("held_data", 32'(datas[i]), 32'h100 + 32'(i));
      if (i > 0) check_eq("held_spacing", 32'(stamps[i] - stamps[i-1]), 32'd22);
    end
  endtask

  task automatic test_ext_and_range();
    do_reset();
    ext_en   = 1'b1;
    ext_data = 12'h123;
    send_cmd(5'd16, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    ext_data = 12'hABC;           // only the value at the RESP edge counts
    wait_resp("ext16", 10, 5'd16, 12'hABC, 1'b1, 1'b1);
    send_cmd(5'd20, 1'b1, 1'b1);
    wait_resp("ext20", CONV, 5'd20, 12'hFFF, 1'b1, 1'b1);
    ext_en = 1'b0;
    send_cmd(5'd17, 1'b1, 1'b1);
    wait_resp("ts17", CONV, 5'd17, 12'h102, 1'b1, 1'b1);
    send_cmd(5'd18, 1'b1, 1'b1);
    wait_resp("ch18", CONV, 5'd18, 12'hFFF, 1'b1, 1'b1);
  endtask

  task automatic test_lock_loss();
    do_reset();
    send_cmd(5'd2, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    locked = 1'b0;
    quiet_window("abort", 30, 0);
    locked = 1'b1;
    #1;
    check_eq("abort_ready_back", 32'(c_ready), 32'd1);
    send_cmd(5'd2, 1'b1, 1'b1);
    wait_resp("after_abort", CONV, 5'd2, 12'h200, 1'b1, 1'b1);
  endtask

  task automatic test_framing();
    do_reset();
    send_cmd(5'd0, 1'b0, 1'b0);
    check_eq("pe_nosop", 32'(proto_err), 32'd1);
    wait_resp("pe_a", CONV, 5'd0, 12'h000, 1'b0, 1'b0);
    send_cmd(5'd0, 1'b1, 1'b1);
    wait_resp("pe_b", CONV, 5'd0, 12'h001, 1'b1, 1'b1);
    check_eq("pe_sticky", 32'(proto_err), 32'd1);
    do_reset();
    send_cmd(5'd1, 1'b1, 1'b0);
    wait_resp("pk_a", CONV, 5'd1, 12'h100, 1'b1, 1'b0);
    send_cmd(5'd1, 1'b0, 1'b0);
    wait_resp("pk_b", CONV, 5'd1, 12'h101, 1'b0, 1'b0);
    send_cmd(5'd1, 1'b0, 1'b1);
    wait_resp("pk_c", CONV, 5'd1, 12'h102, 1'b0, 1'b1);
    check_eq("pk_clean", 32'(proto_err), 32'd0);
    send_cmd(5'd1, 1'b1, 1'b0);
    check_eq("pk_open", 32'(proto_err), 32'd0);
    wait_resp("pk_d", CONV, 5'd1, 12'h103, 1'b1, 1'b0);
    send_cmd(5'd1, 1'b1, 1'b1);
    check_eq("pe_double_sop", 32'(proto_err), 32'd1);
    wait_resp("pk_e", CONV, 5'd1, 12'h104, 1'b1, 1'b1);
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      send_cmd(5'd0, 1'b1, 1'b1);
      wait_resp("wrap", CONV, 5'd0, 12'(i % 256), 1'b1, 1'b1);
    end
    // Reset pulse in the middle of a conversion: no response afterwards.
    send_cmd(5'd5, 1'b1, 1'b1);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    check_eq("midrst_valid", 32'(r_valid), 32'd0);
    check_eq("midrst_data",  32'(r_data),  32'd0);
    rst_n = 1'b1;
    quiet_window("midrst", 30, 30);
    send_cmd(5'd3, 1'b1, 1'b1);
    wait_resp("postrst", CONV, 5'd3, 12'h300, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    locked    = 1'b1;
    c_valid   = 1'b0;
    c_channel = 5'd0;
    c_sop     = 1'b0;
    c_eop     = 1'b0;
    ext_en    = 1'b0;
    ext_data  = 12'h000;

    test_basic();
    test_held_valid();
    test_ext_and_range();
    test_lock_loss();
    test_framing();
    test_wrap_and_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
